// File: rtl/apu_pwm_mixer_if.sv
// Channel-generator side of the APU audio mixer: per-channel samples and mute
// mask in, modulated pin bit plus frame/level status out.
interface apu_pwm_mixer_if #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 4
);
    localparam int MAX   = CHANNELS * ((1 << SAMPLE_W) - 1);
    localparam int LVL_W = $clog2(MAX + 1);

    logic [CHANNELS*SAMPLE_W-1:0] samples;
    logic [CHANNELS-1:0]          mute;
    logic                         mode;
    logic                         pwm;
    logic                         frame;
    logic [LVL_W-1:0]             level;

    // APU side: drives samples and configuration, observes the modulator
    modport master (
        output samples, mute, mode,
        input  pwm, frame, level
    );

    // Mixer side
    modport slave (
        input  samples, mute, mode,
        output pwm, frame, level
    );
endinterface

// File: rtl/apu_pwm_mixer.sv
// N-channel audio mixer with a 1-bit output modulator (PWM or first-order
// sigma-delta). Samples, mutes and mode are latched once per frame of MAX
// modulator ticks; the latched sum drives the modulator for that frame.
module apu_pwm_mixer #(
    parameter int CHANNELS = 4,
    parameter int SAMPLE_W = 4,
    parameter int CLKDIV   = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    apu_pwm_mixer_if.slave bus
);
    localparam int MAX    = CHANNELS * ((1 << SAMPLE_W) - 1);
    localparam int LVL_W  = $clog2(MAX + 1);
    localparam int PRE_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int MAX_M1 = MAX - 1;
    localparam int PRE_M1 = CLKDIV - 1;

    localparam logic [LVL_W:0]   MAX_X    = MAX[LVL_W:0];
    localparam logic [LVL_W-1:0] CNT_LAST = MAX_M1[LVL_W-1:0];
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_M1[PRE_W-1:0];

    logic [PRE_W-1:0] pre_q,   pre_d;
    logic [LVL_W-1:0] cnt_q,   cnt_d;
    logic [LVL_W-1:0] acc_q,   acc_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             mode_q,  mode_d;
    logic             pwm_q,   pwm_d;
    logic             frame_q, frame_d;

    logic             tick;
    logic             frame_start;
    logic [LVL_W-1:0] sum;
    logic [LVL_W-1:0] lvl_e;
    logic             mode_e;
    logic [LVL_W-1:0] acc_base;
    logic [LVL_W:0]   t;

    // Prescaler: tick in the last cycle of each CLKDIV-cycle period
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // Masked channel sum; LVL_W is wide enough that it can never overflow
    always_comb begin
        sum = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!bus.mute[k]) begin
                sum = sum + LVL_W'(bus.samples[k*SAMPLE_W +: SAMPLE_W]);
            end
        end
    end

    // Frame start uses the live inputs so the latch tick already reflects them
    always_comb begin
        frame_start = tick && (cnt_q == '0);
        lvl_e       = frame_start ? sum      : level_q;
        mode_e      = frame_start ? bus.mode : mode_q;
        acc_base    = (frame_start && (bus.mode != mode_q)) ? '0 : acc_q;
        t           = {1'b0, acc_base} + {1'b0, lvl_e};
    end

    // Next-state for frame latch, frame counter and the modulator
    always_comb begin
        level_d = level_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_base;
        pwm_d   = pwm_q;
        frame_d = frame_start;

        if (frame_start) begin
            level_d = sum;
            mode_d  = bus.mode;
        end

        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (!mode_e) begin
                // High interval sits at the start of the frame
                pwm_d = (cnt_q < lvl_e);
            end else if (t >= MAX_X) begin
                pwm_d = 1'b1;
                acc_d = LVL_W'(t - MAX_X);
            end else begin
                pwm_d = 1'b0;
                acc_d = t[LVL_W-1:0];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            level_q <= '0;
            mode_q  <= 1'b0;
            pwm_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            mode_q  <= mode_d;
            pwm_q   <= pwm_d;
            frame_q <= frame_d;
        end
    end

    assign bus.pwm   = pwm_q;
    assign bus.frame = frame_q;
    assign bus.level = level_q;

endmodule

// File: doc/apu_pwm_mixer.md
Name: apu_pwm_mixer

Overview:
- Parametrised N-channel audio mixer and 1-bit DAC modulator for the chiptune APU. Successor to the single-channel PWM audio path.
- Sums per-channel unsigned samples, with a per-channel mute mask, once per output frame.
- Drives one pin through the external 4 kHz low-pass filter, in either PWM mode or first-order sigma-delta mode, selectable at run time.
- Instantiated between the APU channel generators and the pwm output pin.

Parameters:
- CHANNELS, 4: number of mixed channels, 1..8.
- SAMPLE_W, 4: bits per channel sample, unsigned.
- CLKDIV, 1: clk cycles per modulator tick, >=1.
- Derived, not overridable:
  - MAX = CHANNELS*(2^SAMPLE_W-1), full-scale sum and frame length in ticks.
  - LVL_W = bits needed to hold MAX.

Ports:
- clk      input   1                  system clock, 12 MHz
- rst_n    input   1                  active-low reset, synchronous to clk
- samples  input   CHANNELS*SAMPLE_W  packed samples; channel k at [k*SAMPLE_W +: SAMPLE_W]
- mute     input   CHANNELS           1 = channel k excluded from sum
- mode     input   1                  0 = PWM, 1 = sigma-delta
- pwm      output  1                  modulated audio bit, registered
- frame    output  1                  one-clk pulse: new frame latched
- level    output  LVL_W              sum latched for current frame

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n; all state is sampled on the rising edge of clk.
- Reset values: pwm=0, frame=0, level=0, prescaler=0, cnt=0, acc=0, mode_q=0.
- Prescaler:
  - Counts 0..CLKDIV-1. tick is asserted in the cycle where the prescaler is at CLKDIV-1, then it wraps to 0.
  - When CLKDIV=1, tick is high every cycle.
- Frame counter cnt (LVL_W bits):
  - Advances only on tick; wraps MAX-1 -> 0. Frame length = MAX ticks.
- Frame start = tick && cnt==0. On frame start:
  - sum = sum over k of (mute[k] ? 0 : samples[k]), computed at full LVL_W with no overflow possible.
  - level <= sum; mode_q <= mode; frame <= 1 on the next cycle, for exactly one clk.
  - If mode differs from mode_q, acc <= 0 before accumulating.
  - All inputs are sampled only at frame start; changes mid-frame are ignored until the next frame.
- Effective level: lvl_e = sum at frame start, level otherwise. Effective mode: mode_e = mode at frame start, mode_q otherwise.
- PWM mode (mode_e=0), on each tick: pwm <= (cnt < lvl_e).
  - lvl_e=0 gives a constant 0; lvl_e=MAX gives a constant 1.
  - The high interval is contiguous at the start of the frame.
- Sigma-delta mode (mode_e=1), on each tick: t = acc + lvl_e, using an LVL_W+1 bit adder.
  - If t >= MAX: pwm <= 1 and acc <= t - MAX.
  - Else: pwm <= 0 and acc <= t.
  - Ones per frame equal level, ±1 carried across frame boundaries. acc is never reset at a frame boundary unless the mode changes.
- pwm, acc and cnt hold between ticks.
- Reset asserted mid-frame: the next cycle matches the reset values exactly. The first frame start is at the first tick after release.
- Latency: input change to latch is at most MAX*CLKDIV clk cycles. The latch tick's pwm value reflects the new level.

Test Plan:
- Defaults (MAX=60, CLKDIV=1), mode=0, samples={4'd3,4'd0,4'd15,4'd2}, mute=0 -> level=20 after the first frame pulse; pwm high for 20 cycles then low for 40, repeating every 60; frame pulses every 60 clk.
- mode=0, all samples 15, mute=0 -> level=60, pwm constant 1. Set mute=4'b1111 -> from the next frame start, level=0 and pwm constant 0.
- mode=1, level=15 (one channel at 15, others muted) -> exactly 15 ones per 60 ticks, pwm high every 4th tick; level=59 -> exactly one zero per frame.
- CLKDIV=3, mode=0, level=20 -> frame period 180 clk; pwm high for 60 consecutive clk; frame pulse width 1 clk.
- Change samples and mode mid-frame (cnt=30) -> pwm, level and mode are unchanged until cnt wraps to 0; acc is cleared on the mode switch.
- Assert rst_n=0 for 1 cycle at cnt=45, mode=1 -> next cycle pwm=0, level=0, frame=0, internal cnt=0, acc=0; the first frame pulse follows one tick after release.
